uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- UART transmit serializer directly downstream of the tx-data select mux.
- Accepts a parallel word via a start/busy handshake.
- Emits a standard asynchronous frame on tx: 1 start bit, DATA_BITS data bits LSB-first, optional parity, 1 stop bit.
- Flags completion so the controlling FSM can advance its select and load the next word.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s.
- DATA_BITS, 8: payload bits per frame, legal range 5..9.

Ports:
- clk  input  1  system clock; rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to send data_in; sampled only in IDLE.
- data_in  input  DATA_BITS  word to transmit (mux output Q, low DATA_BITS).
- tx  output  1  serial line; idle high; registered.
- busy  output  1  high from the cycle after start is accepted until the frame ends.
- done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Derived constant: CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer truncation; 434 at defaults). Elaboration error if it is < 2.
- Reset (async, any time, including mid-frame): state=IDLE, tx=1, busy=0, done=0, baud counter=0, bit index=0, shift register=0. Frame is abandoned with no partial stop bit.
- Internal registers:
  - baud counter, width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, then wraps to 0 and asserts bit_end.
  - bit index, width $clog2(DATA_BITS+1).
  - shift register, DATA_BITS wide.
- IDLE:
  - tx=1, busy=0.
  - If start=1 at edge N: latch data_in into shift register; state->START; busy=1 and tx=0 from edge N+1.
- START: tx=0 for exactly CLKS_PER_BIT cycles; on bit_end state->DATA, bit index=0.
- DATA:
  - tx=shift[0]; each bit held CLKS_PER_BIT cycles.
  - On bit_end: shift right, bit index++.
  - After bit DATA_BITS-1: state->PARITY if the feature is enabled, else STOP.
- PARITY (feature only): tx=parity bit for CLKS_PER_BIT cycles, then state->STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On bit_end: state->IDLE, busy=0, done=1 for exactly that next cycle.
- Frame length: (DATA_BITS+2[+1]) * CLKS_PER_BIT cycles from the first tx low to busy low.
- Handshake:
  - start while busy=1 is ignored; no queuing.
  - start in the same cycle done=1 is accepted (state is already IDLE). Back-to-back frames are separated by exactly 1 idle-high cycle.
- data_in is sampled only on the accept edge; later changes do not affect the frame in flight.
- start held high continuously: a new frame begins at every IDLE cycle.
- State encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4 (3 bits). Illegal state -> IDLE with tx=1.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: PARITY state is compiled in.
  - Transmits even parity = XOR of the latched word, captured at accept.
  - Frame grows by one bit time.
- Undefined: PARITY state and parity register are absent; DATA goes straight to STOP.

Decomposition:
- Package uart_pkg:
  - state localparams IDLE/START/DATA/PARITY/STOP, STATE_W=3;
  - function clks_per_bit(clk_freq, baud);
  - TX_IDLE_LEVEL=1'b1.
- One sub-module, uart_baud_counter: inputs clk, rst, clear, enable; output bit_end. Parameter CLKS_PER_BIT; clear forces the count to 0.
- Top contains the FSM, shift register and bit index.

Test Plan:
- Bench params CLK_FREQ=1_000_000, BAUD_RATE=100_000 (10 clk/bit), DATA_BITS=8, no parity.
  - Reset then idle 50 cycles -> tx=1, busy=0, done=0 throughout.
  - start=1 for 1 cycle at edge 0 with data_in=8'hA5 -> tx low cycles 1-10, then bits 1,0,1,0,0,1,0,1 each 10 cycles, stop high cycles 91-100, done=1 only at cycle 101, busy falls at 101.
  - start held high, data_in=8'h00 then 8'hFF -> two frames separated by exactly 1 idle cycle; second frame carries the value present at its accept edge.
  - start pulsed at cycle 40 during a frame with data_in=8'h3C -> ignored; frame unchanged, no extra done.
  - rst asserted at cycle 55 mid-frame -> tx=1 and busy=0 immediately (async); after release plus start with 8'h01, a clean frame is sent.
- With UART_TX_PARITY_EN defined, data_in=8'h07 -> parity bit 1 during cycles 91-100, stop at 101-110, done at 111.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmit path.
//   STATE_W / IDLE..STOP : transmitter FSM encoding (3 bits)
//   TX_IDLE_LEVEL        : line level while no frame is in flight
//   clks_per_bit()       : system clocks per bit time (truncating divide)
package uart_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] START  = 3'd1;
    localparam logic [STATE_W-1:0] DATA   = 3'd2;
    localparam logic [STATE_W-1:0] PARITY = 3'd3;
    localparam logic [STATE_W-1:0] STOP   = 3'd4;

    localparam logic TX_IDLE_LEVEL = 1'b1;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter -- bit-time divider for the UART transmitter.
//   clk, rst : clock, async active-high reset
//   clear    : forces the count to 0 (held while the line is idle)
//   enable   : advance the count
//   bit_end  : high in the last clock of each bit time; count wraps to 0 there
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign bit_end = enable && !clear && (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= bit_end ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer -- UART frame transmitter behind the tx-data select mux.
//   clk, rst : clock, async active-high reset
//   start    : send request, only looked at while idle
//   data_in  : word to send, captured on the accepting edge
//   tx       : registered serial line (idle high)
//   busy     : frame in flight
//   done     : one-cycle pulse after the stop bit
// Frame: start bit, DATA_BITS data bits LSB first, [even parity], stop bit.
// Build option: define UART_TX_PARITY_EN to add the even-parity bit.
module uart_tx_serializer #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);
    import uart_pkg::*;

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int IDX_W        = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_serializer: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $error("uart_tx_serializer: DATA_BITS must be 5..9");
    end

    logic [STATE_W-1:0]   state, state_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
    logic                 tx_nxt, busy_nxt, done_nxt;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_nxt;
`endif

    // Count only while a frame is in flight so every bit starts from 0.
    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE),
        .enable  (state != IDLE),
        .bit_end (bit_end)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            tx      <= TX_IDLE_LEVEL;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            shift   <= shift_nxt;
            bit_idx <= bit_idx_nxt;
            tx      <= tx_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_nxt;
`endif
        end
    end

    // Next state plus shift register / bit index.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_idx_nxt = bit_idx;
`ifdef UART_TX_PARITY_EN
        parity_nxt  = parity_q;
`endif
        case (state)
            IDLE: if (start) begin
                state_nxt = START;
                shift_nxt = data_in;
`ifdef UART_TX_PARITY_EN
                parity_nxt = ^data_in;
`endif
            end
            START: if (bit_end) begin
                state_nxt   = DATA;
                bit_idx_nxt = '0;
            end
            DATA: if (bit_end) begin
                shift_nxt   = shift >> 1;
                bit_idx_nxt = bit_idx + 1'b1;
                if (bit_idx == LAST_IDX)
`ifdef UART_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) state_nxt = STOP;
`endif
            STOP: if (bit_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered line
    // changes on the same edge as the state.
    always_comb begin
        tx_nxt   = TX_IDLE_LEVEL;
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state == STOP) && bit_end;
        case (state_nxt)
            START:  tx_nxt = 1'b0;
            DATA:   tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_nxt = parity_nxt;
`endif
            default: tx_nxt = TX_IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer -- directed bench, 10 clocks per bit, 8 data bits.
// Cycle c of a frame is the clock period after the c-th edge following the
// one where start was raised; tx goes low in cycle 1.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int CPB   = 10;
    localparam int NSLOT = 8 + int'(PAR);
    localparam int LAST  = (NSLOT + 2) * CPB + 1;   // cycle with done=1

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] data_in;
    logic       tx, busy, done;

    int checks   = 0;
    int failures = 0;

    uart_tx_serializer #(
        .CLK_FREQ  (1_000_000),
        .BAUD_RATE (100_000),
        .DATA_BITS (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic exp_tx(input logic [7:0] d, input int c);
        int slot;
        if (c <= CPB) return 1'b0;
        slot = (c - CPB - 1) / CPB;
        if (slot < 8) return d[slot];
        if (PAR && slot == 8) return ^d;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("%s tx %0d", tag, i), tx, 1'b1);
            chk($sformatf("%s busy %0d", tag, i), busy, 1'b0);
            chk($sformatf("%s done %0d", tag, i), done, 1'b0);
        end
    endtask

    // Caller raises start/data_in just before. Runs cycles 1..last_c.
    task automatic frame(input logic [7:0] d, input int last_c, input bit keep_start,
                         input int glitch_c, input int chg_c, input logic [7:0] chg_d);
        for (int c = 1; c <= last_c; c++) begin
            step();
            if (c == 1) start = keep_start;
            if (c == glitch_c) begin start = 1'b1; data_in = 8'h3C; end
            if (c == glitch_c + 1) start = 1'b0;
            if (c == chg_c) data_in = chg_d;
            chk($sformatf("f%h tx c%0d", d, c), tx, exp_tx(d, c));
            chk($sformatf("f%h busy c%0d", d, c), busy, c < LAST);
            chk($sformatf("f%h done c%0d", d, c), done, c == LAST);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; data_in = 8'h00;
        #2;
        chk("reset tx", tx, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        step(); step();
        rst = 1'b0;
        idle(50, "idle50");

        // single frame
        data_in = 8'hA5; start = 1'b1;
        frame(8'hA5, LAST, 1'b0, -5, -5, 8'h00);
        idle(3, "postA5");

        // start held high: 00 then FF, data_in changes mid-frame
        data_in = 8'h00; start = 1'b1;
        frame(8'h00, LAST, 1'b1, -5, 50, 8'hFF);
        frame(8'hFF, LAST, 1'b0, -5, -5, 8'h00);
        idle(3, "postFF");

        // start pulse while busy is ignored
        data_in = 8'hC3; start = 1'b1;
        frame(8'hC3, LAST, 1'b0, 40, -5, 8'h00);
        idle(20, "postglitch");

        // async reset mid-frame (tx low at cycle 55 for 0F)
        data_in = 8'h0F; start = 1'b1;
        frame(8'h0F, 55, 1'b0, -5, -5, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst tx", tx, 1'b1);
        chk("async rst busy", busy, 1'b0);
        chk("async rst done", done, 1'b0);
        step();
        chk("in rst tx", tx, 1'b1);
        chk("in rst busy", busy, 1'b0);
        #2;
        rst = 1'b0;
        idle(2, "afterrst");
        data_in = 8'h01; start = 1'b1;
        frame(8'h01, LAST, 1'b0, -5, -5, 8'h00);
        idle(3, "post01");

        // odd-weight word (parity bit 1 when the option is built in)
        data_in = 8'h07; start = 1'b1;
        frame(8'h07, LAST, 1'b0, -5, -5, 8'h00);
        idle(3, "post07");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
